// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and types for the seven-segment scan driver.
//   DIGIT_W            : width of one BCD digit in the packed input bus
//   SEG_0 .. SEG_9     : active-high segment patterns, bit 0 = a .. bit 6 = g
//   SEG_DASH           : pattern shown for non-decimal nibbles (10..15)
//   SEG_BLANK          : all segments off
package seg7_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;
  typedef logic [6:0]         seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
// Purely combinational BCD nibble to seven-segment pattern decode.
// Ports:
//   bcd_i [3:0] : digit value; 0..9 decode to numerals, 10..15 to a dash
//   seg_o [6:0] : active-high segments, seg_o[0]=a .. seg_o[6]=g
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [6:0]         seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a NUM_DIGITS-digit seven-segment display.
// A shadow register captures the BCD digits and decimal points on load;
// a prescaler holds each digit lit for SCAN_DIV cycles while the digit
// index walks 0..NUM_DIGITS-1. Display outputs are registered from the
// current index and shadow contents (one cycle behind them).
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digit k>=1 is blanked when it and every higher digit
//   hold zero. Digit 0 is never blanked; an and dp are not affected.
//
// Ports:
//   clk        : rising-edge clock
//   clear_n    : asynchronous active-low reset
//   bcd_in     : packed BCD digits, [3:0] is digit 0 (least significant)
//   dp_in      : decimal-point request per digit
//   load       : capture strobe for bcd_in / dp_in
//   seg        : segment drive, active-high, seg[0]=a .. seg[6]=g
//   dp         : decimal-point drive, active-high
//   an         : one-hot digit enable, active-high
//   frame_done : one-cycle pulse at the end of each full scan
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          clear_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = DIGIT_W * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Scan state
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic                  presc_wrap;

  // Shadow of the displayed value
  logic [BW-1:0]         bcd_q,   bcd_d;
  logic [NUM_DIGITS-1:0] dpsh_q,  dpsh_d;

  // Registered display drive
  logic [6:0]            seg_q,   seg_d;
  logic                  dp_q,    dp_d;
  logic [NUM_DIGITS-1:0] an_q,    an_d;

  // Selected digit
  logic [DIGIT_W-1:0]    sel_digit;
  logic                  sel_dp;
  logic [6:0]            dec_seg;

  // ---------------------------------------------------------------------
  // Prescaler and digit index. Load never touches these, so a capture
  // that lands on an index advance simply happens alongside it.
  // ---------------------------------------------------------------------
  always_comb begin
    presc_wrap = (presc_q == PRESC_LAST);
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Shadow capture
  // ---------------------------------------------------------------------
  always_comb begin
    bcd_d  = bcd_q;
    dpsh_d = dpsh_q;
    if (load) begin
      bcd_d  = bcd_in;
      dpsh_d = dp_in;
    end
  end

  // ---------------------------------------------------------------------
  // Digit select and one-hot enable, both from the current index.
  // ---------------------------------------------------------------------
  always_comb begin
    sel_digit = '0;
    sel_dp    = 1'b0;
    an_d      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_digit = bcd_q[k*DIGIT_W +: DIGIT_W];
        sel_dp    = dpsh_q[k];
        an_d[k]   = 1'b1;
      end
    end
  end

  seg7_decoder u_decoder (
    .bcd_i (sel_digit),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is excluded so a value of zero still shows a single "0".
  logic zero_from_sel;

  always_comb begin
    zero_from_sel = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IW'(k) >= idx_q) && (bcd_q[k*DIGIT_W +: DIGIT_W] != '0)) begin
        zero_from_sel = 1'b0;
      end
    end
  end

  always_comb begin
    seg_d = dec_seg;
    if ((idx_q != '0) && zero_from_sel) begin
      seg_d = SEG_BLANK;
    end
  end
`else
  always_comb begin
    seg_d = dec_seg;
  end
`endif

  always_comb begin
    dp_d = sel_dp;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      bcd_q   <= '0;
      dpsh_q  <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      an_q    <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      dpsh_q  <= dpsh_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  // Decoded straight from the scan registers so it drops with clear_n.
  assign frame_done = presc_wrap && (idx_q == IDX_LAST);

endmodule
